// File: rtl/fc_pkg.sv
// -----------------------------------------------------------------------------
// fc_pkg
// Shared types for the fully-connected layer wrappers.
//   act_t        : one activation value at the default layer width
//   bank_state_t : per-bank life cycle of a staging bank
//   bank_state() : maps a bank's full/filling flags onto bank_state_t
// -----------------------------------------------------------------------------
package fc_pkg;

  localparam int ACT_W = 8;

  typedef logic [ACT_W-1:0] act_t;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

  // FULL wins over FILLING: a bank holding a frame is never written.
  function automatic bank_state_t bank_state(input logic full, input logic filling);
    if (full) begin
      return FULL;
    end else if (filling) begin
      return FILLING;
    end
    return EMPTY;
  endfunction

endpackage

// File: rtl/fc_act_bank.sv
// -----------------------------------------------------------------------------
// fc_act_bank
// One IN x WIDTH activation register bank. Written one entry per cycle,
// read as a full parallel vector.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (clears every entry)
//   i_we      : write enable for this cycle
//   i_idx     : entry to write
//   i_data    : value to write
//   o_vec     : all IN entries, unpacked, index 0 first
// -----------------------------------------------------------------------------
module fc_act_bank
  import fc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IN    = 128,
  parameter int IDX_W = (IN > 1) ? $clog2(IN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_vec [0:IN-1]
);

  logic [WIDTH-1:0] r_mem [0:IN-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < IN; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_idx] <= i_data;
    end
  end

  always_comb begin
    for (int i = 0; i < IN; i++) begin
      o_vec[i] = r_mem[i];
    end
  end

endmodule

// File: rtl/fc_act_buffer.sv
// -----------------------------------------------------------------------------
// fc_act_buffer
// Double-banked input staging buffer for a fully-connected layer. Serial
// activations are collected into one bank while the other bank is held
// stable on x for the layer. Frames whose length disagrees with s_last are
// dropped and counted.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   s_valid/s_ready : input beat handshake
//   s_data, s_last  : activation value, final-beat marker
//   m_valid/m_ready : frame handshake; m_ready releases the presented frame
//   x               : IN-entry activation vector from the read bank
//   err_len         : one-cycle pulse after a frame is dropped
//   drop_cnt        : saturating dropped-frame count
//   dbg_bank_state  : {bank1, bank0} bank_state_t, for observation only
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds its payload until that edge. s_ready comes
// from registered state only (no path from m_ready); x is frozen while
// m_valid && !m_ready and is meaningless while m_valid is low.
// -----------------------------------------------------------------------------
module fc_act_buffer
  import fc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IN    = 128,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] x [0:IN-1],
  output logic             err_len,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [3:0]       dbg_bank_state
);

  localparam int IDX_W = (IN > 1) ? $clog2(IN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN - 1);

  // Registered state
  logic [IDX_W-1:0] r_idx;
  logic             r_wr_sel;
  logic             r_rd_sel;
  logic [1:0]       r_full;
  logic             r_err;
  logic [CNT_W-1:0] r_drop_cnt;

  // Next-state
  logic [IDX_W-1:0] w_idx_nxt;
  logic             w_wr_sel_nxt;
  logic             w_rd_sel_nxt;
  logic [1:0]       w_full_nxt;
  logic             w_err_nxt;
  logic [CNT_W-1:0] w_drop_nxt;

  logic             w_accept;
  logic             w_release;
  logic             w_at_end;
  logic             w_we0;
  logic             w_we1;
  logic [WIDTH-1:0] w_vec0 [0:IN-1];
  logic [WIDTH-1:0] w_vec1 [0:IN-1];
  bank_state_t      w_st0;
  bank_state_t      w_st1;

  assign s_ready   = !r_full[r_wr_sel];
  assign m_valid   = r_full[r_rd_sel];
  assign err_len   = r_err;
  assign drop_cnt  = r_drop_cnt;

  assign w_accept  = s_valid && s_ready;
  assign w_release = m_valid && m_ready;
  assign w_at_end  = (r_idx == LAST_IDX);

  // Every accepted beat is written, including beats of a frame that later
  // turns out malformed; the bank is simply not marked full in that case.
  assign w_we0 = w_accept && !r_wr_sel;
  assign w_we1 = w_accept &&  r_wr_sel;

  fc_act_bank #(.WIDTH(WIDTH), .IN(IN), .IDX_W(IDX_W)) u_bank0 (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_we0),
    .i_idx  (r_idx),
    .i_data (s_data),
    .o_vec  (w_vec0)
  );

  fc_act_bank #(.WIDTH(WIDTH), .IN(IN), .IDX_W(IDX_W)) u_bank1 (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_we1),
    .i_idx  (r_idx),
    .i_data (s_data),
    .o_vec  (w_vec1)
  );

  // Control next-state. A completion and a release in one cycle always hit
  // different banks: completion needs full[wr_sel]==0, release needs
  // full[rd_sel]==1, so both updates to w_full_nxt can be applied.
  always_comb begin
    w_idx_nxt    = r_idx;
    w_wr_sel_nxt = r_wr_sel;
    w_rd_sel_nxt = r_rd_sel;
    w_full_nxt   = r_full;
    w_err_nxt    = 1'b0;
    w_drop_nxt   = r_drop_cnt;

    if (w_accept) begin
      if (w_at_end && s_last) begin
        w_full_nxt[r_wr_sel] = 1'b1;
        w_wr_sel_nxt         = !r_wr_sel;
        w_idx_nxt            = '0;
      end else if (w_at_end || s_last) begin
        // Early s_last or missing s_last: restart the same bank.
        w_idx_nxt = '0;
        w_err_nxt = 1'b1;
        if (r_drop_cnt != {CNT_W{1'b1}}) begin
          w_drop_nxt = r_drop_cnt + 1'b1;
        end
      end else begin
        w_idx_nxt = r_idx + 1'b1;
      end
    end

    if (w_release) begin
      w_full_nxt[r_rd_sel] = 1'b0;
      w_rd_sel_nxt         = !r_rd_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx      <= '0;
      r_wr_sel   <= 1'b0;
      r_rd_sel   <= 1'b0;
      r_full     <= 2'b00;
      r_err      <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_idx      <= w_idx_nxt;
      r_wr_sel   <= w_wr_sel_nxt;
      r_rd_sel   <= w_rd_sel_nxt;
      r_full     <= w_full_nxt;
      r_err      <= w_err_nxt;
      r_drop_cnt <= w_drop_nxt;
    end
  end

  // Present the read bank.
  always_comb begin
    for (int k = 0; k < IN; k++) begin
      x[k] = r_rd_sel ? w_vec1[k] : w_vec0[k];
    end
  end

  // A bank is FILLING once the write bank has taken at least one beat.
  always_comb begin
    w_st0 = bank_state(r_full[0], !r_wr_sel && (r_idx != '0));
    w_st1 = bank_state(r_full[1],  r_wr_sel && (r_idx != '0));
    dbg_bank_state = {w_st1, w_st0};
  end

endmodule
